// File: rtl/matrix_result_serializer.sv
// Captures one flattened 5x5 ALU result and streams it element by element over a valid/ready beat interface.
// Optional trailing status beat carrying the overflow flag: define RESULT_STATUS_BEAT_EN.
module matrix_result_serializer #(
    parameter int N_ELEM = 25,
    parameter int ELEM_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_ELEM*ELEM_W-1:0] C_flat,
    input  logic                     overflow_flag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_last,
    output logic                     done,
    output logic                     busy,
    output logic [7:0]               ovf_count
);

    // state     | meaning
    // IDLE      | waiting for a result, in_ready high
    // SEND      | streaming element idx from the shadow register
    // STATUS    | single trailing status beat (feature build only)
    // DONE      | one-cycle done pulse before returning to IDLE
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd3;
`ifdef RESULT_STATUS_BEAT_EN
    localparam logic [1:0] ST_STATUS = 2'd2;
    localparam logic       LAST_ON_ELEM = 1'b0;
`else
    localparam logic       LAST_ON_ELEM = 1'b1;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);

    logic [1:0]               state;
    logic [N_ELEM*ELEM_W-1:0] shadow;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W-1:0]        nxt_idx;
`ifdef RESULT_STATUS_BEAT_EN
    logic                     ovf_reg;
`endif

    assign nxt_idx = idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ovf_count <= 8'd0;
`ifdef RESULT_STATUS_BEAT_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (flush) begin
            // Abort without a done pulse; the overflow count survives.
            state     <= ST_IDLE;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        shadow    <= C_flat;
                        idx       <= '0;
                        state     <= ST_SEND;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= C_flat[ELEM_W-1:0];
                        out_addr  <= '0;
                        out_last  <= LAST_ON_ELEM && (LAST_IDX == '0);
                        if (overflow_flag && ovf_count != 8'hFF)
                            ovf_count <= ovf_count + 8'd1;
`ifdef RESULT_STATUS_BEAT_EN
                        ovf_reg   <= overflow_flag;
`endif
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (idx != LAST_IDX) begin
                            idx      <= nxt_idx;
                            out_data <= shadow[nxt_idx*ELEM_W +: ELEM_W];
                            out_addr <= nxt_idx;
                            out_last <= LAST_ON_ELEM && (nxt_idx == LAST_IDX);
                        end else begin
`ifdef RESULT_STATUS_BEAT_EN
                            state    <= ST_STATUS;
                            out_data <= {{(ELEM_W-1){1'b0}}, ovf_reg};
                            out_addr <= ADDR_W'(N_ELEM);
                            out_last <= 1'b1;
`else
                            state     <= ST_DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
`endif
                        end
                    end
                end
`ifdef RESULT_STATUS_BEAT_EN
                ST_STATUS: begin
                    if (out_ready) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state    <= ST_IDLE;
                    done     <= 1'b0;
                    idx      <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer; follows RESULT_STATUS_BEAT_EN to expect the status beat.
module tb_matrix_result_serializer;

`ifdef RESULT_STATUS_BEAT_EN
    localparam int NB = 26;
`else
    localparam int NB = 25;
`endif

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] C_flat;
    logic         overflow_flag;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [4:0]   out_addr;
    logic         out_last;
    logic         done;
    logic         busy;
    logic [7:0]   ovf_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_data [25];

    matrix_result_serializer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .C_flat(C_flat), .overflow_flag(overflow_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .done(done), .busy(busy), .ovf_count(ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] base);
        for (int i = 0; i < 25; i++) begin
            exp_data[i] = base + 8'(i);
            C_flat[i*8 +: 8] = base + 8'(i);
        end
    endtask

    // Drives in_valid at a negedge and returns just after the capturing posedge.
    task automatic capture(input logic ovf);
        @(negedge clk);
        in_valid = 1'b1;
        overflow_flag = ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic recv(input bit stall, input logic ovf);
        int k;
        int cyc;
        logic rdy;
        logic [7:0] ed;
        k = 0;
        cyc = 0;
        while (k < NB && cyc < 200) begin
            @(negedge clk);
            rdy = (stall && cyc[0]) ? 1'b0 : 1'b1;
            ed = (k < 25) ? exp_data[k] : {7'b0, ovf};
            chk($sformatf("beat%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("beat%0d_addr", k), 32'(out_addr), 32'(k));
            chk($sformatf("beat%0d_data", k), 32'(out_data), 32'(ed));
            chk($sformatf("beat%0d_last", k), 32'(out_last), 32'(k == NB - 1));
            chk($sformatf("beat%0d_done", k), 32'(done), 32'd0);
            chk($sformatf("beat%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("beat%0d_busy", k), 32'(busy), 32'd1);
            out_ready = rdy;
            if (rdy) k++;
            cyc++;
        end
        chk("recv_beats_in_budget", 32'(k), 32'(NB));
        @(negedge clk);
        out_ready = 1'b1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int caps;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        overflow_flag = 1'b0;
        out_ready = 1'b1;
        C_flat = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-rate transfer, values 1..25.
        load(8'd1);
        capture(1'b0);
        in_valid = 1'b0;
        recv(1'b0, 1'b0);
        @(negedge clk);
        chk("t1_in_ready_after_done", 32'(in_ready), 32'd1);
        chk("t1_done_cleared", 32'(done), 32'd0);
        chk("t1_busy_cleared", 32'(busy), 32'd0);
        chk("t1_ovf_count", 32'(ovf_count), 32'd0);

        // Stalls on odd cycles; operands overwritten with 0xFF after capture.
        load(8'd1);
        capture(1'b0);
        in_valid = 1'b0;
        C_flat = {200{1'b1}};
        recv(1'b1, 1'b0);

        // Overflowed result, in_valid held high with new operands during the transfer.
        load(8'h30);
        capture(1'b1);
        for (int i = 0; i < 25; i++) C_flat[i*8 +: 8] = 8'hA0 + 8'(i);
        recv(1'b0, 1'b1);
        @(negedge clk);
        chk("t3_in_ready_back", 32'(in_ready), 32'd1);
        chk("t3_busy_low", 32'(busy), 32'd0);
        chk("t3_ovf_count_no_recapture", 32'(ovf_count), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        load(8'hA0);
        recv(1'b0, 1'b1);
        chk("t4_ovf_count_second", 32'(ovf_count), 32'd2);

        // Flush at element 10.
        @(negedge clk);
        load(8'd1);
        capture(1'b0);
        in_valid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (out_addr != 5'd10 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_reached_addr10", 32'(out_addr), 32'd10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_out_valid_low", 32'(out_valid), 32'd0);
        chk("t5_no_done", 32'(done), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ovf_retained", 32'(ovf_count), 32'd2);
        @(negedge clk);
        chk("t5_still_no_done", 32'(done), 32'd0);

        // flush coincident with in_valid in IDLE.
        flush = 1'b1;
        in_valid = 1'b1;
        overflow_flag = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5b_no_capture_busy", 32'(busy), 32'd0);
        chk("t5b_in_ready", 32'(in_ready), 32'd1);
        chk("t5b_ovf_count", 32'(ovf_count), 32'd2);

        // 300 overflowed captures then an async reset mid-transfer.
        caps = 0;
        cyc = 0;
        in_valid = 1'b1;
        overflow_flag = 1'b1;
        out_ready = 1'b1;
        while (caps < 300 && cyc < 12000) begin
            @(negedge clk);
            if (in_ready) caps++;
            cyc++;
        end
        chk("t6_captures_in_budget", 32'(caps), 32'd300);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_ovf_saturated", 32'(ovf_count), 32'd255);
        cyc = 0;
        while (out_addr != 5'd5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_busy_mid", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_data", 32'(out_data), 32'd0);
        chk("t6_rst_out_addr", 32'(out_addr), 32'd0);
        chk("t6_rst_out_last", 32'(out_last), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ovf_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_rst_no_done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Downstream stage of the scalar/matrix ALU: captures one flattened 5x5 result (C_flat plus overflow_flag) per handshake.
- Streams the elements one per beat, with element index, over a valid/ready byte interface toward the result memory / host-readback path.
- Keeps a saturating count of overflowed results.
- Decouples the combinational ALU output from the slower writeback path so the ALU operands can change after capture.

Parameters:
- N_ELEM, 25, number of matrix elements per result (5x5)
- ELEM_W, 8, element width in bits
- ADDR_W, 5, element index width; must satisfy 2**ADDR_W > N_ELEM

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  ALU result valid (ALU done qualified by controller)
- in_ready  output  1  block can capture a result
- C_flat  input  N_ELEM*ELEM_W  flattened result; element i at bits [i*ELEM_W +: ELEM_W]
- overflow_flag  input  1  ALU overflow for this result
- out_valid  output  1  out_data/out_addr/out_last valid
- out_ready  input  1  downstream accepts beat
- out_data  output  ELEM_W  element value
- out_addr  output  ADDR_W  element index (0..N_ELEM-1; N_ELEM for status beat)
- out_last  output  1  final beat of this result
- done  output  1  one-cycle pulse, result fully transferred
- busy  output  1  high in any state except IDLE
- ovf_count  output  8  saturating count of captured results with overflow_flag=1

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_addr=0, out_last=0, done=0, busy=0, ovf_count=0, shadow registers=0.
- All outputs are registered; no combinational path from out_ready or in_valid to any output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture C_flat into the shadow register and overflow_flag into ovf_reg. Set idx=0. Increment ovf_count if overflow_flag=1, saturating at 255. Go to SEND.
  - SEND: out_valid=1, out_data=shadow[idx*ELEM_W +: ELEM_W], out_addr=idx.
    - out_last=1 only when idx==N_ELEM-1 and no status beat follows.
    - On out_valid&&out_ready: if idx<N_ELEM-1, idx++; otherwise go to STATUS (feature enabled) or DONE.
  - STATUS (feature only): single status beat; see Optional Feature.
  - DONE: done=1 for exactly one cycle, out_valid=0. Next state IDLE with in_ready=1.
- Latency:
  - First out_valid appears the cycle after the capture handshake.
  - With out_ready held high, one beat per cycle: N_ELEM beats (N_ELEM+1 with the status beat).
  - done rises the cycle after the last beat handshake.
  - in_ready rises the cycle after done.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data, out_addr and out_last hold stable.
  - in_ready=0 in every state except IDLE; in_valid there is ignored, with no capture and no count change.
- Shadow register: holds its value for the whole transfer regardless of C_flat changes.
- flush: synchronous, highest priority after reset.
  - Next state IDLE; out_valid=0, idx=0, done not pulsed; ovf_count retained.
  - A beat handshaken in the flush cycle counts as delivered.
  - flush in IDLE coincident with in_valid: no capture, no count change.
- Reset mid-transfer: immediate return to reset values, including ovf_count; no done pulse.
- Index wrap: idx never exceeds N_ELEM-1 in SEND; no wrap to 0 within a result.

Optional Feature:
- Macro: RESULT_STATUS_BEAT_EN
- Defined:
  - After element N_ELEM-1 is accepted, the block enters STATUS and emits one extra beat: out_addr=N_ELEM (25), out_data={7'b0, ovf_reg}, out_last=1.
  - The element-24 beat has out_last=0.
  - done follows the status beat handshake.
- Undefined:
  - STATUS state and logic are absent.
  - The element-24 beat carries out_last=1 and is followed directly by DONE.
  - The overflow is visible only via ovf_count.

Test Plan:
- Elements i=0..24 with value i+1, overflow_flag=0, out_ready=1 -> 25 beats on consecutive cycles, out_addr 0..24, out_data 1..25, out_last only on addr 24 (macro off), done one cycle later, ovf_count=0.
- Same load; out_ready low on odd cycles; C_flat changed to all 0xFF after capture -> out_data/out_addr stable while stalled, all 25 original values delivered, no 0xFF seen.
- RESULT_STATUS_BEAT_EN defined, overflow_flag=1 -> 26th beat out_addr=25, out_data=0x01, out_last=1; element-24 beat out_last=0; ovf_count=1.
- in_valid held high during a transfer -> no second capture; ovf_count unchanged; next capture happens only after in_ready returns high.
- flush asserted at out_addr=10 with out_ready=1 -> beat 10 delivered, out_valid low next cycle, no done, in_ready=1, ovf_count retained.
- 300 captures with overflow_flag=1, then rst_n pulsed low mid-transfer -> ovf_count saturates at 255; all outputs drop to reset values asynchronously.
